// File: rtl/wz_batch_if.sv
// ---------------------------------------------------------------------------
// wz_batch_if
//   Bundles the host command channel, the encoder-core port and the shared
//   single-port RAM port of the working-zone batch controller.
//
//   Command handshake: the host raises cmd_valid with cmd_count stable; the
//   controller raises cmd_ready only while idle. A command is accepted on a
//   rising clock edge where cmd_valid && cmd_ready. Nothing is queued, so
//   cmd_valid while cmd_ready is low is simply ignored.
//
//   Modports
//     master : host / encoder core / RAM side (the environment)
//     slave  : the batch controller
//
//   Signals
//     cmd_valid, cmd_ready, cmd_count[7:0]         command channel
//     busy, batch_done, err_timeout, jobs_done[7:0] status
//     enc_start, enc_done                           encoder run handshake
//     enc_address[15:0], enc_en, enc_we, enc_data   encoder RAM request
//     mem_address[15:0], mem_en, mem_we, mem_wdata  RAM request (muxed)
//     mem_rdata[7:0]                                RAM read data (1-cycle latency)
// ---------------------------------------------------------------------------
interface wz_batch_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_count;
  logic        busy;
  logic        batch_done;
  logic        err_timeout;
  logic [7:0]  jobs_done;

  logic        enc_start;
  logic        enc_done;
  logic [15:0] enc_address;
  logic        enc_en;
  logic        enc_we;
  logic [7:0]  enc_data;

  logic [15:0] mem_address;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output cmd_valid, cmd_count,
    input  cmd_ready, busy, batch_done, err_timeout, jobs_done,
    input  enc_start,
    output enc_done, enc_address, enc_en, enc_we, enc_data,
    input  mem_address, mem_en, mem_we, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  cmd_valid, cmd_count,
    output cmd_ready, busy, batch_done, err_timeout, jobs_done,
    output enc_start,
    input  enc_done, enc_address, enc_en, enc_we, enc_data,
    output mem_address, mem_en, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/wz_batch_controller.sv
// ---------------------------------------------------------------------------
// wz_batch_controller
//   Batch sequencer and RAM arbiter for the working-zone encoder core.
//   For each of N jobs it copies source entry k (RAM[SRC_BASE+k]) into the
//   encoder's input slot RAM[8], runs one encoder start/done handshake, then
//   copies the encoded byte from RAM[9] to RAM[DST_BASE+k].
//   The controller owns the RAM port except while enc_start is high; then
//   the encoder's request is passed straight through.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous, active-high reset
//   bus        wz_batch_if.slave (command, status, encoder and RAM signals)
//   dbg_state  current FSM state encoding
// ---------------------------------------------------------------------------
module wz_batch_controller #(
  parameter logic [15:0] SRC_BASE = 16'd16,
  parameter logic [15:0] DST_BASE = 16'd32,
  parameter int          TIMEOUT  = 64
) (
  input  logic           i_clk,
  input  logic           i_rst,
  wz_batch_if.slave      bus,
  output logic [3:0]     dbg_state
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [15:0] ENC_IN_ADDR  = 16'd8;
  localparam logic [15:0] ENC_OUT_ADDR = 16'd9;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_SRC    = 4'd1,
    S_WAIT_RD   = 4'd2,
    S_WR_ADDR   = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_RD_RES    = 4'd5,
    S_WAIT_RES  = 4'd6,
    S_WR_DST    = 4'd7,
    S_RELEASE   = 4'd8,
    S_FIN       = 4'd9
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    count_q;    // N, latched on accept
  logic [7:0]    k_q;        // current job index
  logic [7:0]    jobs_q;     // completed jobs
  logic [7:0]    hold_q;     // byte in flight (source entry, then result)
  logic [TW-1:0] timer_q;    // cycles spent in WAIT_DONE
  logic          err_q;
  logic          done_q;

  logic          accept;
  logic          timer_expired;
  logic          last_job;

  // controller-side RAM request before the arbitration mux
  logic [15:0]   ctl_address;
  logic          ctl_en;
  logic          ctl_we;
  logic [7:0]    ctl_wdata;
  logic          enc_grant;

  assign accept        = bus.cmd_valid && (state == S_IDLE);
  assign timer_expired = (timer_q == TIMER_LAST);
  assign last_job      = ((k_q + 8'd1) == count_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (bus.cmd_count == 8'd0) ? S_FIN : S_RD_SRC;
        end
      end
      S_RD_SRC:  state_nxt = S_WAIT_RD;
      S_WAIT_RD: state_nxt = S_WR_ADDR;
      S_WR_ADDR: state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // done wins over the timeout, including a done already high on entry
        if (bus.enc_done) begin
          state_nxt = S_RD_RES;
        end else if (timer_expired) begin
          state_nxt = S_FIN;
        end
      end
      S_RD_RES:   state_nxt = S_WAIT_RES;
      S_WAIT_RES: state_nxt = S_WR_DST;
      S_WR_DST:   state_nxt = S_RELEASE;
      S_RELEASE: begin
        // the encoder must have dropped done before the next start
        if (!bus.enc_done) begin
          state_nxt = last_job ? S_FIN : S_RD_SRC;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Controller RAM request per state
  // -------------------------------------------------------------------------
  always_comb begin
    ctl_address = 16'd0;
    ctl_en      = 1'b0;
    ctl_we      = 1'b0;
    ctl_wdata   = 8'd0;
    case (state)
      S_RD_SRC: begin
        ctl_address = SRC_BASE + {8'd0, k_q};
        ctl_en      = 1'b1;
      end
      S_WR_ADDR: begin
        ctl_address = ENC_IN_ADDR;
        ctl_en      = 1'b1;
        ctl_we      = 1'b1;
        ctl_wdata   = hold_q;
      end
      S_RD_RES: begin
        ctl_address = ENC_OUT_ADDR;
        ctl_en      = 1'b1;
      end
      S_WR_DST: begin
        ctl_address = DST_BASE + {8'd0, k_q};
        ctl_en      = 1'b1;
        ctl_we      = 1'b1;
        ctl_wdata   = hold_q;
      end
      default: begin
        ctl_address = 16'd0;
        ctl_en      = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // RAM arbitration. i_rst gates the grant and the controller request so a
  // reset mid-batch cuts both the encoder and the RAM port off immediately,
  // without waiting for the clock edge.
  // -------------------------------------------------------------------------
  assign enc_grant = (state == S_WAIT_DONE) && !i_rst;

  always_comb begin
    bus.mem_address = 16'd0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_wdata   = 8'd0;
    if (enc_grant) begin
      bus.mem_address = bus.enc_address;
      bus.mem_en      = bus.enc_en;
      bus.mem_we      = bus.enc_we;
      bus.mem_wdata   = bus.enc_data;
    end else if (!i_rst) begin
      bus.mem_address = ctl_address;
      bus.mem_en      = ctl_en;
      bus.mem_we      = ctl_we;
      bus.mem_wdata   = ctl_wdata;
    end
  end

  assign bus.enc_start   = enc_grant;
  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.busy        = (state != S_IDLE);
  assign bus.batch_done  = done_q;
  assign bus.err_timeout = err_q;
  assign bus.jobs_done   = jobs_q;
  assign dbg_state       = state;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      count_q <= 8'd0;
      k_q     <= 8'd0;
      jobs_q  <= 8'd0;
      hold_q  <= 8'd0;
      timer_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      // registered so the pulse lands in the cycle after FIN
      done_q <= (state == S_FIN);
      case (state)
        S_IDLE: begin
          if (accept) begin
            count_q <= bus.cmd_count;
            k_q     <= 8'd0;
            jobs_q  <= 8'd0;
            err_q   <= 1'b0;
          end
        end
        S_WAIT_RD:  hold_q  <= bus.mem_rdata;
        S_WR_ADDR:  timer_q <= '0;
        S_WAIT_DONE: begin
          if (!bus.enc_done) begin
            if (timer_expired) begin
              err_q <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end
        S_WAIT_RES: hold_q <= bus.mem_rdata;
        S_RELEASE: begin
          if (!bus.enc_done) begin
            jobs_q <= jobs_q + 8'd1;
            k_q    <= k_q + 8'd1;
          end
        end
        default: begin
          hold_q <= hold_q;
        end
      endcase
    end
  end

endmodule
